// File: rtl/wos_pkg.sv
// Shared defaults and FSM encoding for the weighted rank-order front end.
package wos_pkg;

  localparam int unsigned N_DEFAULT           = 5;
  localparam int unsigned DATA_BITS_DEFAULT   = 8;
  localparam int unsigned WEIGHT_BITS_DEFAULT = 3;
  localparam int unsigned WEIGHT_RESET        = 1;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } wos_state_e;

endpackage

// File: rtl/weight_regfile.sv
// Per-tap weight storage: one guarded write port, one async read port.
module weight_regfile
  import wos_pkg::*;
#(
  parameter int unsigned N           = N_DEFAULT,
  parameter int unsigned WEIGHT_BITS = WEIGHT_BITS_DEFAULT,
  parameter int unsigned TAP_BITS    = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [TAP_BITS-1:0]    waddr,
  input  logic [WEIGHT_BITS-1:0] wdata,
  input  logic [TAP_BITS-1:0]    raddr,
  output logic [WEIGHT_BITS-1:0] rdata
);

  localparam logic [TAP_BITS:0] N_LIM = (TAP_BITS+1)'(N);

  logic [WEIGHT_BITS-1:0] regs [N];
  logic                   wr_ok;
  logic                   rd_ok;

  // Out-of-range addresses are dropped rather than aliased.
  assign wr_ok = we && ({1'b0, waddr} < N_LIM);
  assign rd_ok = {1'b0, raddr} < N_LIM;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        regs[i] <= WEIGHT_BITS'(WEIGHT_RESET);
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = rd_ok ? regs[raddr] : '0;

endmodule

// File: rtl/weight_expander.sv
// Replicates each accepted sample weight[tap] times for a downstream
// rank-order filter; weight 0 drops the sample.
module weight_expander
  import wos_pkg::*;
#(
  parameter int unsigned N           = N_DEFAULT,
  parameter int unsigned DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int unsigned WEIGHT_BITS = WEIGHT_BITS_DEFAULT,
  parameter int unsigned TAP_BITS    = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_BITS-1:0]   in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_BITS-1:0]   out,
  output logic                   out_valid,
  input  logic                   cfg_we,
  input  logic [TAP_BITS-1:0]    cfg_addr,
  input  logic [WEIGHT_BITS-1:0] cfg_weight,
  output logic [TAP_BITS-1:0]    tap
);

  wos_state_e             state;
  wos_state_e             state_nxt;
  logic [WEIGHT_BITS-1:0] remaining;
  logic [WEIGHT_BITS-1:0] remaining_nxt;
  logic [TAP_BITS-1:0]    tap_nxt;
  logic [DATA_BITS-1:0]   out_nxt;
  logic                   out_valid_nxt;
  logic [WEIGHT_BITS-1:0] tap_weight;
  logic                   last_beat;
  logic                   accept;
  logic                   weight_nz;

  weight_regfile #(
    .N          (N),
    .WEIGHT_BITS(WEIGHT_BITS),
    .TAP_BITS   (TAP_BITS)
  ) u_regfile (
    .clk  (clk),
    .rst  (rst),
    .we   (cfg_we),
    .waddr(cfg_addr),
    .wdata(cfg_weight),
    .raddr(tap),
    .rdata(tap_weight)
  );

  // Ready on the final replica so weight-1 traffic streams back to back.
  assign last_beat = (state == EMIT) && (remaining == WEIGHT_BITS'(1));
  assign in_ready  = rst && ((state == IDLE) || last_beat);
  assign accept    = in_valid && in_ready;
  assign weight_nz = (tap_weight != '0);

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    tap_nxt       = tap;
    out_nxt       = out;
    out_valid_nxt = 1'b0;

    if (accept) begin
      tap_nxt = (tap == TAP_BITS'(N - 1)) ? '0 : tap + TAP_BITS'(1);
    end

    case (state)
      IDLE: begin
        if (accept && weight_nz) begin
          state_nxt     = EMIT;
          remaining_nxt = tap_weight;
          out_nxt       = in;
        end
      end
      EMIT: begin
        if (!last_beat) begin
          remaining_nxt = remaining - WEIGHT_BITS'(1);
        end else if (accept && weight_nz) begin
          remaining_nxt = tap_weight;
          out_nxt       = in;
        end else begin
          state_nxt     = IDLE;
          remaining_nxt = '0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        remaining_nxt = '0;
      end
    endcase

    out_valid_nxt = (state_nxt == EMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      tap       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      tap       <= tap_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_weight_expander.sv
// Randomized scoreboard bench for weight_expander against a cycle-schedule model.
module tb_weight_expander;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dout;
  logic       out_valid;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [2:0] cfg_weight;
  logic [2:0] tap;

  weight_expander dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (dout),
    .out_valid (out_valid),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_weight(cfg_weight),
    .tap       (tap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   rst_seen = 1'b0;
  int   last_out = 0;

  // Model state: weights, tap, earliest edge at which a sample may be taken.
  int   m_wt[N];
  int   m_tap = 0;
  int   next_edge = 0;
  bit   tap_known = 1'b0;
  bit   last_acc = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) last_out = 0;
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_out: got out_valid=1 data %0h expected no output (cycle %0d)", dout, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", 32'(dout), 32'(e.d));
          chk("out_cycle", 32'(cyc), 32'(e.c));
          last_out = e.d;
        end
      end else begin
        if (q.size() > 0 && q[0].c <= cyc) begin
          exp_t e;
          e = q.pop_front();
          chk("out_valid", 32'(out_valid), 32'd1);
        end
        chk("out_hold", 32'(dout), 32'(last_out));
      end
    end
  end

  task automatic model_reset(input int k);
    for (int i = 0; i < N; i++) m_wt[i] = 1;
    m_tap     = 0;
    next_edge = k + 2;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].c > k) q.delete(i);
    end
  endtask

  // One clock cycle of stimulus, plus in_ready/tap checks and model update.
  task automatic step(input bit v, input int d, input bit we, input int a, input int w, input bit r_n);
    int k;
    bit exp_rdy;
    int wv;
    @(posedge clk);
    #1;
    k          = cyc;
    rst        = r_n;
    in_valid   = v;
    din        = 8'(d);
    cfg_we     = we;
    cfg_addr   = 3'(a);
    cfg_weight = 3'(w);
    #1;
    exp_rdy = r_n && (k + 1 >= next_edge);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (tap_known) chk("tap", 32'(tap), 32'(m_tap));
    last_acc = 1'b0;
    if (!r_n) begin
      model_reset(k);
      tap_known = 1'b1;
    end else begin
      if (v && exp_rdy) begin
        last_acc = 1'b1;
        wv = m_wt[m_tap];
        for (int i = 0; i < wv; i++) q.push_back('{d: d & 255, c: k + 1 + i});
        next_edge = k + 1 + ((wv > 0) ? wv : 1);
        m_tap = (m_tap + 1) % N;
      end
      if (we && a < N) m_wt[a] = w;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int a, input int w);
    step(1'b0, 0, 1'b1, a, w, 1'b1);
  endtask

  // Hold in_valid with the same sample until the model says it was taken.
  task automatic send(input int d);
    int tries = 0;
    last_acc = 1'b0;
    while (!last_acc && tries < 40) begin
      step(1'b1, d, 1'b0, 0, 0, 1'b1);
      tries++;
    end
    if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 60) begin
      idle(1);
      n++;
    end
    idle(1);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; din = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_weight = '0;
    for (int i = 0; i < N; i++) m_wt[i] = 1;

    do_reset(2);
    mon_en = 1'b1;
    idle(2);

    // Pass-through with reset weights.
    for (int i = 1; i <= 5; i++) send(10 * i);
    drain();

    // Out-of-range write is ignored.
    step(1'b0, 0, 1'b1, 5, 0, 1'b1);
    for (int i = 1; i <= 5; i++) send(10 * i);
    drain();

    // Mixed weights including a dropped sample; tap wraps.
    wr(0, 2); wr(1, 1); wr(2, 3); wr(3, 0); wr(4, 1);
    for (int i = 5; i <= 9; i++) send(i);
    drain();

    // Maximum weight.
    wr(0, 7);
    send(8'hFF);
    drain();

    // Weight write during an in-flight emission of the same tap.
    do_reset(1);
    idle(1);
    wr(0, 2);
    send(8'hA0);
    wr(0, 4);
    for (int i = 1; i <= 5; i++) send(8'hA0 + i);
    drain();

    // Reset on the second cycle of a weight-3 emission.
    do_reset(1);
    idle(1);
    wr(0, 3);
    send(8'hC3);
    idle(1);
    do_reset(1);
    idle(2);
    for (int i = 1; i <= 5; i++) send(i);
    drain();

    // Simultaneous write to the tap being accepted uses the old weight.
    step(1'b1, 8'h77, 1'b1, m_tap, 0, 1'b1);
    chk("simul_accept", 32'(last_acc), 32'd1);
    drain();

    // Random traffic with occasional resets and out-of-range writes.
    for (int i = 0; i < 400; i++) begin
      bit r_n;
      r_n = ($urandom_range(0, 49) != 0);
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)),
           $urandom_range(0, 9) < 3, int'($urandom_range(0, 5)),
           int'($urandom_range(0, 7)), r_n);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
